mem_interface: RTL
==================

Name: mem_interface

Overview:
- Sits directly upstream of the memory array, between the datapath bus/control FSM and the 16-bit word memory.
- Owns the MAR and MDR registers and sequences multi-cycle memory reads and writes.
- Decodes the LC-3-style memory-mapped I/O page (keyboard and display registers) and returns the ready flag R to the control FSM.
- Gates MDR onto the datapath bus.

Parameters:
- MEM_LATENCY, 3, cycles mem_en is held per memory access (legal range 1..15).
- KBSR_ADDR, 16'hFE00, keyboard status address.
- KBDR_ADDR, 16'hFE02, keyboard data address.
- DSR_ADDR, 16'hFE04, display status address.
- DDR_ADDR, 16'hFE06, display data address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- BUS  in  16  datapath bus value.
- LDMAR  in  1  load MAR from BUS.
- LDMDR  in  1  load MDR: from BUS when MIO_EN=0, from read data at completion when MIO_EN=1.
- MIO_EN  in  1  memory/IO access request, held by the FSM until R is seen.
- R_W  in  1  1 = write, 0 = read; sampled at access start.
- GATEMDR  in  1  drive MDR onto BUS_OUT.
- MAR  out  16  memory address register.
- MDR  out  16  memory data register.
- BUS_OUT  out  16  MDR when GATEMDR=1, else 16'h0000.
- R  out  1  access-complete flag, one-cycle pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  equals MAR.
- mem_wdata  out  16  equals MDR.
- mem_rdata  in  16  memory read data, valid on the last mem_en cycle.
- kb_valid  in  1  one-cycle pulse: new key available.
- kb_data  in  8  key code.
- ddr_strobe  out  1  one-cycle pulse: DDR written.
- ddr_data  out  16  DDR contents.
- disp_ack  in  1  one-cycle pulse: display consumed the character.

Behaviour:
- Reset (synchronous, dominates everything, aborts an in-flight access with no memory write completed afterwards):
  - State goes to IDLE; cnt is cleared.
  - MAR, MDR, KBDR, DDR = 0; KBSR = 0; DSR = 16'h8000.
  - R, mem_en, mem_we, ddr_strobe = 0.
- LDMAR=1: MAR <= BUS at the next edge, in any state. The FSM must not change MAR during BUSY; if it does, the behaviour is unspecified.
- LDMDR with MIO_EN=0: MDR <= BUS.
- LDMDR with MIO_EN=1: MDR loads only in DONE and only for a read; at any other time it is ignored.
- States and transitions: IDLE, BUSY, DONE, HOLD.
  - IDLE: on MIO_EN=1, latch we_l <= R_W.
    - If MAR is one of the four I/O addresses: go to DONE (R one cycle after MIO_EN is sampled).
    - Otherwise: go to BUSY with cnt <= MEM_LATENCY-1.
  - BUSY: mem_en=1, mem_we=we_l.
    - When cnt==0: capture rd_l <= mem_rdata and go to DONE.
    - Otherwise: cnt decrements.
    - Memory access latency is MEM_LATENCY+1 cycles from MIO_EN sampled to R=1.
  - DONE: R=1 for exactly this cycle.
    - Read with LDMDR=1: MDR <= rd_l (memory) or the selected device register.
    - Next state is HOLD if MIO_EN is still 1, else IDLE.
  - HOLD: wait for MIO_EN=0, then go to IDLE. This prevents a duplicate access when the FSM drops MIO_EN late.
- I/O reads:
  - KBSR returns {KBSR[15], 15'b0}.
  - KBDR returns {8'h00, kb_data latched}; completing a KBDR read clears KBSR[15].
  - DSR returns {DSR[15], 15'b0}.
  - DDR returns DDR.
- I/O writes:
  - DDR: in DONE, DDR <= MDR, DSR[15] <= 0, ddr_strobe=1 for that cycle.
  - Writes to KBSR, KBDR and DSR are ignored: no state change, R still pulses.
- kb_valid: KBDR <= kb_data and KBSR[15] <= 1.
  - If it coincides with a KBDR read completing, the new data is kept and KBSR[15] stays 1.
  - A second kb_valid before the read overwrites KBDR (no queue).
- disp_ack sets DSR[15] <= 1. If it coincides with a DDR write in DONE, the write wins and DSR[15]=0.
- Addresses in page xFE00 other than the four listed go to memory.
- BUS_OUT is combinational from GATEMDR and MDR.

Test Plan:
- Reset, then check: MAR=0, MDR=0, DSR=16'h8000, R=0, BUS_OUT=0. Assert reset during BUSY -> next cycle state is IDLE, mem_en=0, R never pulses.
- Read, MEM_LATENCY=3: LDMAR with BUS=16'h3000; memory[3000]=16'hBEEF; MIO_EN=1, R_W=0, LDMDR=1 -> mem_en high for 3 cycles, R at cycle 4, MDR=16'hBEEF, GATEMDR gives BUS_OUT=16'hBEEF.
- Write: MAR=16'h3001, MDR loaded from BUS=16'h1234, MIO_EN=1, R_W=1 -> mem_we=1 with mem_addr=16'h3001, mem_wdata=16'h1234 for 3 cycles; R pulses once; hold MIO_EN 2 extra cycles -> no second access (HOLD state).
- Keyboard: kb_valid with kb_data=8'h41 -> KBSR read returns 16'h8000; KBDR read returns 16'h0041, then KBSR reads 16'h0000; kb_valid coincident with KBDR read -> KBSR stays 16'h8000.
- Display: write MDR=16'h0048 to 16'hFE06 -> R one cycle after MIO_EN, ddr_strobe pulse, ddr_data=16'h0048, DSR=0; disp_ack -> DSR=16'h8000; disp_ack coincident with DDR write -> DSR=0.
- MEM_LATENCY=1 and an undecoded address 16'hFE08 -> memory access, R 2 cycles after MIO_EN; write to KBSR -> R pulses, KBSR unchanged.

Source files
------------

// File: rtl/mem_interface.sv
// MAR/MDR owner and memory/IO access sequencer for an LC-3 style datapath.
// Decodes the keyboard/display page and pulses R when an access completes.
module mem_interface #(
   parameter int          MEM_LATENCY = 3,
   parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
   parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
   parameter logic [15:0] DSR_ADDR    = 16'hFE04,
   parameter logic [15:0] DDR_ADDR    = 16'hFE06
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] BUS,
   input  logic        LDMAR,
   input  logic        LDMDR,
   input  logic        MIO_EN,
   input  logic        R_W,
   input  logic        GATEMDR,
   output logic [15:0] MAR,
   output logic [15:0] MDR,
   output logic [15:0] BUS_OUT,
   output logic        R,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   output logic        ddr_strobe,
   output logic [15:0] ddr_data,
   input  logic        disp_ack
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        we_l;
   logic [15:0] rd_l;
   logic        kbsr;
   logic [7:0]  kbdr;
   logic        dsr;
   logic [15:0] ddr;

   logic        hit_kbsr;
   logic        hit_kbdr;
   logic        hit_dsr;
   logic        hit_ddr;
   logic        is_io;
   logic        rd_done;
   logic        wr_done;
   logic [15:0] rd_val;

   assign hit_kbsr = (MAR == KBSR_ADDR);
   assign hit_kbdr = (MAR == KBDR_ADDR);
   assign hit_dsr  = (MAR == DSR_ADDR);
   assign hit_ddr  = (MAR == DDR_ADDR);
   assign is_io    = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

   // MAR is frozen for the whole access, so the decode stays valid in DONE
   assign rd_done = (state == DONE) && !we_l;
   assign wr_done = (state == DONE) && we_l;

   always_comb begin
      rd_val = rd_l;
      unique case (1'b1)
         hit_kbsr: rd_val = {kbsr, 15'b0};
         hit_kbdr: rd_val = {8'h00, kbdr};
         hit_dsr:  rd_val = {dsr, 15'b0};
         hit_ddr:  rd_val = ddr;
         default:  rd_val = rd_l;
      endcase
   end

   assign BUS_OUT   = GATEMDR ? MDR : 16'h0000;
   assign mem_addr  = MAR;
   assign mem_wdata = MDR;
   assign ddr_data  = ddr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         we_l       <= 1'b0;
         rd_l       <= 16'h0000;
         MAR        <= 16'h0000;
         MDR        <= 16'h0000;
         kbsr       <= 1'b0;
         kbdr       <= 8'h00;
         dsr        <= 1'b1;
         ddr        <= 16'h0000;
         R          <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         ddr_strobe <= 1'b0;
      end else begin
         if (LDMAR)
            MAR <= BUS;

         if (LDMDR && !MIO_EN)
            MDR <= BUS;
         else if (LDMDR && rd_done)
            MDR <= rd_val;

         if (rd_done && hit_kbdr)
            kbsr <= 1'b0;
         if (kb_valid) begin
            kbdr <= kb_data;
            kbsr <= 1'b1;
         end

         // a DDR write completing beats a coincident display ack
         if (disp_ack)
            dsr <= 1'b1;
         if (wr_done && hit_ddr)
            dsr <= 1'b0;

         R          <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         ddr_strobe <= 1'b0;

         unique case (state)
            IDLE: begin
               if (MIO_EN) begin
                  we_l <= R_W;
                  if (is_io) begin
                     state <= DONE;
                     R     <= 1'b1;
                     if (R_W && hit_ddr) begin
                        ddr        <= MDR;
                        ddr_strobe <= 1'b1;
                     end
                  end else begin
                     state  <= BUSY;
                     cnt    <= 4'(MEM_LATENCY - 1);
                     mem_en <= 1'b1;
                     mem_we <= R_W;
                  end
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  rd_l  <= mem_rdata;
                  state <= DONE;
                  R     <= 1'b1;
               end else begin
                  cnt    <= cnt - 4'd1;
                  mem_en <= 1'b1;
                  mem_we <= we_l;
               end
            end
            DONE: begin
               state <= MIO_EN ? HOLD : IDLE;
            end
            HOLD: begin
               if (!MIO_EN)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
